// File: rtl/hamming_scrubber_pkg.sv
// Shared types and Hamming geometry helpers for the background ECC scrubber.
package hamming_scrubber_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT     = 3'd1;
    localparam state_t ST_READ     = 3'd2;
    localparam state_t ST_CHECK    = 3'd3;
    localparam state_t ST_EVALUATE = 3'd4;
    localparam state_t ST_WRITE    = 3'd5;
    localparam state_t ST_ADVANCE  = 3'd6;

    // Smallest r with 2^r >= data_width + r + 1.
    function automatic int parity_width(input int data_width);
        int r;
        r = 1;
        for (int i = 1; i < 30; i++) begin
            r = ((1 << i) < data_width + i + 1) ? i + 1 : r;
        end
        return r;
    endfunction

    // 1-based codeword position of data bit k; powers of two hold parity.
    function automatic int data_pos(input int k);
        int p;
        p = k + 1;
        for (int j = 0; j < 30; j++) begin
            p = ((1 << j) <= p) ? p + 1 : p;
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_scrubber_codec.sv
// Hamming SEC encoder and decoder; parity bits sit at power-of-two positions.
module hamming_encoder
    import hamming_scrubber_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH),
    localparam int BLOCK_WIDTH = DATA_WIDTH + PARITY_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [BLOCK_WIDTH-1:0] block
);

    logic [PARITY_WIDTH-1:0] parity_s;

    // Parity j covers every data position whose index has bit j set.
    always_comb begin
        parity_s = '0;
        for (int j = 0; j < PARITY_WIDTH; j++) begin
            for (int k = 0; k < DATA_WIDTH; k++) begin
                parity_s[j] = parity_s[j] ^ ((((data_pos(k) >> j) & 1) == 1) ? data[k] : 1'b0);
            end
        end
    end

    // Scatter data and parity into codeword positions.
    always_comb begin
        block = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            block[data_pos(k) - 1] = data[k];
        end
        for (int j = 0; j < PARITY_WIDTH; j++) begin
            block[(1 << j) - 1] = parity_s[j];
        end
    end

endmodule

module hamming_decoder
    import hamming_scrubber_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH),
    localparam int BLOCK_WIDTH = DATA_WIDTH + PARITY_WIDTH
) (
    input  logic [BLOCK_WIDTH-1:0]  block,
    output logic [PARITY_WIDTH-1:0] syndrome,
    output logic [DATA_WIDTH-1:0]   data
);

    logic [BLOCK_WIDTH-1:0] fixed_s;

    // Syndrome is the XOR of the positions of all set bits.
    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= BLOCK_WIDTH; p++) begin
            syndrome = syndrome ^ (block[p-1] ? PARITY_WIDTH'(p) : PARITY_WIDTH'(0));
        end
    end

    // Flip the addressed bit and gather the payload back out.
    always_comb begin
        fixed_s = '0;
        data    = '0;
        for (int p = 1; p <= BLOCK_WIDTH; p++) begin
            fixed_s[p-1] = block[p-1] ^ (syndrome == PARITY_WIDTH'(p));
        end
        for (int k = 0; k < DATA_WIDTH; k++) begin
            data[k] = fixed_s[data_pos(k) - 1];
        end
    end

endmodule

// File: rtl/hamming_scrubber.sv
// Background scrubber: walks the memory in idle cycles and rewrites blocks
// carrying a correctable single-bit error.
module hamming_scrubber
    import hamming_scrubber_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int INTERVAL_WIDTH = 16,
    parameter int COUNT_WIDTH    = 16,
    localparam int ADDRESS_WIDTH = $clog2(DEPTH),
    localparam int PARITY_WIDTH  = parity_width(DATA_WIDTH),
    localparam int BLOCK_WIDTH   = DATA_WIDTH + PARITY_WIDTH
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    input  logic                      memory_busy,
    output logic                      read_enable,
    output logic [ADDRESS_WIDTH-1:0]  read_address,
    input  logic [BLOCK_WIDTH-1:0]    read_block,
    output logic                      write_enable,
    output logic [ADDRESS_WIDTH-1:0]  write_address,
    output logic [BLOCK_WIDTH-1:0]    write_block,
    output logic                      busy,
    output logic                      corrected_pulse,
    output logic                      sweep_done,
    output logic [COUNT_WIDTH-1:0]    corrected_count
);

    localparam logic [PARITY_WIDTH-1:0]  LAST_POS  = PARITY_WIDTH'(BLOCK_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                    state_r, state_s;
    logic [ADDRESS_WIDTH-1:0]  address_r;
    logic [INTERVAL_WIDTH-1:0] wait_r;
    logic [BLOCK_WIDTH-1:0]    block_r;
    logic [COUNT_WIDTH-1:0]    count_r;
    logic [PARITY_WIDTH-1:0]   syndrome_s;
    logic [DATA_WIDTH-1:0]     data_s;
    logic                      reload_s, read_s, write_s, wrap_s;

    hamming_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_decoder (
        .block    (block_r),
        .syndrome (syndrome_s),
        .data     (data_s)
    );

    hamming_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_encoder (
        .data  (data_s),
        .block (write_block)
    );

    // Next state and access strobes; strobes only fire on an idle memory.
    always_comb begin
        state_s  = state_r;
        reload_s = 1'b0;
        read_s   = 1'b0;
        write_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_ADVANCE: begin
                if (enable) begin
                    reload_s = 1'b1;
                    state_s  = (interval == '0) ? ST_READ : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT:     state_s = (wait_r <= INTERVAL_WIDTH'(1)) ? ST_READ : ST_WAIT;
            ST_READ: begin
                if (!memory_busy) begin
                    read_s  = 1'b1;
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_CHECK:    state_s = ST_EVALUATE;
            // Syndromes past the last real position come from double errors.
            ST_EVALUATE: state_s = (syndrome_s == '0 || syndrome_s > LAST_POS) ? ST_ADVANCE : ST_WRITE;
            ST_WRITE: begin
                if (!memory_busy) begin
                    write_s = 1'b1;
                    state_s = ST_ADVANCE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            default:     state_s = ST_IDLE;
        endcase
    end

    assign wrap_s = (state_r == ST_ADVANCE) && (address_r == LAST_ADDR);

    // Scrub state, address walk, pacing counter, captured block and tally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            address_r <= '0;
            wait_r    <= '0;
            block_r   <= '0;
            count_r   <= '0;
        end else begin
            state_r <= state_s;
            if (reload_s) begin
                wait_r <= interval;
            end else if (state_r == ST_WAIT) begin
                wait_r <= wait_r - INTERVAL_WIDTH'(1);
            end
            if (state_r == ST_CHECK) begin
                block_r <= read_block;
            end
            if (state_r == ST_ADVANCE) begin
                address_r <= wrap_s ? '0 : address_r + ADDRESS_WIDTH'(1);
            end
            if (write_s && (count_r != '1)) begin
                count_r <= count_r + COUNT_WIDTH'(1);
            end
        end
    end

    assign read_enable     = read_s;
    assign read_address    = address_r;
    assign write_enable    = write_s;
    assign write_address   = address_r;
    assign busy            = (state_r != ST_IDLE);
    assign corrected_pulse = write_s;
    assign sweep_done      = wrap_s;
    assign corrected_count = count_r;

endmodule

// File: tb/tb_hamming_scrubber.sv
// Directed bench for hamming_scrubber with a one-cycle-latency memory model.
module tb_hamming_scrubber;

    localparam int AW = 4;
    localparam int BW = 12;
    localparam int CW = 16;

    logic          clock, resetn, enable, memory_busy;
    logic [15:0]   interval;
    logic          read_enable, write_enable, busy, corrected_pulse, sweep_done;
    logic [AW-1:0] read_address, write_address;
    logic [BW-1:0] read_block, write_block;
    logic [CW-1:0] corrected_count;

    logic          resetn2, enable2, read_enable2, write_enable2, busy2, pulse2, sweep2;
    logic [AW-1:0] raddr2, waddr2;
    logic [BW-1:0] rblk2, wblk2;
    logic [2:0]    count2;

    logic          mem_init, preset_en;
    logic [AW-1:0] preset_addr;
    logic [BW-1:0] preset_val;
    logic [BW-1:0] mem [16];
    logic [BW-1:0] mem2 [16];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rd_addr[$], rd_cyc[$], wr_addr[$], wr_cyc[$], sw_cyc[$], cp_cyc[$], viol[$];
    logic [BW-1:0] wr_blk[$], wr2_blk[$];

    hamming_scrubber dut (
        .clock(clock), .resetn(resetn), .enable(enable), .interval(interval),
        .memory_busy(memory_busy), .read_enable(read_enable), .read_address(read_address),
        .read_block(read_block), .write_enable(write_enable), .write_address(write_address),
        .write_block(write_block), .busy(busy), .corrected_pulse(corrected_pulse),
        .sweep_done(sweep_done), .corrected_count(corrected_count)
    );

    hamming_scrubber #(.COUNT_WIDTH(3)) dut_sat (
        .clock(clock), .resetn(resetn2), .enable(enable2), .interval(16'd0),
        .memory_busy(1'b0), .read_enable(read_enable2), .read_address(raddr2),
        .read_block(rblk2), .write_enable(write_enable2), .write_address(waddr2),
        .write_block(wblk2), .busy(busy2), .corrected_pulse(pulse2),
        .sweep_done(sweep2), .corrected_count(count2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (preset_en) begin
            mem[preset_addr] <= preset_val;
        end else if (write_enable) begin
            mem[write_address] <= write_block;
        end
        if (read_enable) read_block <= mem[read_address];
    end

    // Every word of the second memory starts with parity bit 1 flipped.
    always @(posedge clock) begin
        if (!resetn2) begin
            for (int i = 0; i < 16; i++) mem2[i] <= 12'h001;
        end else if (write_enable2) begin
            mem2[waddr2] <= wblk2;
        end
        if (read_enable2) rblk2 <= mem2[raddr2];
    end

    always @(negedge clock) begin
        if (read_enable) begin
            rd_addr.push_back(int'(read_address));
            rd_cyc.push_back(cyc);
        end
        if (write_enable) begin
            wr_addr.push_back(int'(write_address));
            wr_cyc.push_back(cyc);
            wr_blk.push_back(write_block);
        end
        if (sweep_done) sw_cyc.push_back(cyc);
        if (corrected_pulse) cp_cyc.push_back(cyc);
        if (write_enable2) wr2_blk.push_back(wblk2);
        if ((read_enable && (write_enable || memory_busy)) || (write_enable && memory_busy) ||
            (corrected_pulse != write_enable) || (read_enable2 && write_enable2) ||
            (pulse2 != write_enable2))
            viol.push_back(cyc);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input logic [AW-1:0] a, input logic [BW-1:0] v);
        preset_addr = a;
        preset_val  = v;
        preset_en   = 1'b1;
        tick();
        preset_en = 1'b0;
    endtask

    task automatic clear_log();
        rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_cyc.delete();
        wr_blk.delete(); sw_cyc.delete(); cp_cyc.delete();
    endtask

    task automatic run_to_sweep(input string tag);
        int n = 0;
        while (!sweep_done && n < 300) begin
            tick();
            n++;
        end
        check_val(tag, sweep_done, 1'b1);
        enable = 1'b0;
    endtask

    task automatic wait_reads(input int cnt, input string tag);
        int n = 0;
        while (rd_addr.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, rd_addr.size(), cnt);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_val(tag, busy, 1'b0);
    endtask

    initial begin
        int c0, cw, nz;
        resetn = 1'b0; resetn2 = 1'b0; enable = 1'b0; enable2 = 1'b0;
        interval = 16'd0; memory_busy = 1'b0; mem_init = 1'b1;
        preset_en = 1'b0; preset_addr = '0; preset_val = '0;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_rd", read_enable, 0);
        check_val("rst_wr", write_enable, 0);
        check_val("rst_addr", read_address, 0);
        check_val("rst_wblk", write_block, 0);
        check_val("rst_cnt", corrected_count, 0);
        check_val("rst_sweep", sweep_done, 0);
        resetn = 1'b1; resetn2 = 1'b1; mem_init = 1'b0;
        tick();
        enable2 = 1'b1;
        preset(4'd3, 12'hF77);
        preset(4'd5, 12'hA27);

        // Clean sweep, back-to-back blocks
        clear_log();
        c0 = cyc; enable = 1'b1;
        run_to_sweep("t1_sweep_seen");
        wait_idle("t1_idle");
        check_val("t1_reads", rd_addr.size(), 16);
        check_val("t1_first_cyc", rd_cyc[0], c0 + 1);
        for (int i = 0; i < rd_addr.size() && i < 16; i++) check_val("t1_addr", rd_addr[i], i);
        for (int i = 1; i < rd_cyc.size() && i < 16; i++) check_val("t1_gap", rd_cyc[i] - rd_cyc[i-1], 4);
        check_val("t1_sweeps", sw_cyc.size(), 1);
        check_val("t1_sweep_cyc", sw_cyc[0], rd_cyc[15] + 3);
        check_val("t1_writes", wr_addr.size(), 0);
        check_val("t1_cnt", corrected_count, 0);

        // Single-bit error at 5, double error (syndrome 13) at 7
        preset(4'd5, 12'hA67);
        preset(4'd7, 12'h801);
        clear_log();
        enable = 1'b1;
        run_to_sweep("t2_sweep_seen");
        wait_idle("t2_idle");
        check_val("t2_reads", rd_addr.size(), 16);
        check_val("t2_writes", wr_addr.size(), 1);
        check_val("t2_waddr", wr_addr[0], 5);
        check_val("t2_wblk", wr_blk[0], 12'hA27);
        check_val("t2_wcyc", wr_cyc[0], rd_cyc[5] + 3);
        check_val("t2_gap_fix", rd_cyc[6] - rd_cyc[5], 5);
        check_val("t2_gap_dbl", rd_cyc[8] - rd_cyc[7], 4);
        check_val("t2_pulses", cp_cyc.size(), 1);
        check_val("t2_cnt", corrected_count, 1);
        check_val("t2_mem5", mem[5], 12'hA27);
        check_val("t2_mem7", mem[7], 12'h801);

        // Functional traffic stalls the read for 10 cycles
        clear_log();
        c0 = cyc; enable = 1'b1; memory_busy = 1'b1;
        repeat (11) tick();
        check_val("t3_no_rd_busy", rd_addr.size(), 0);
        memory_busy = 1'b0; enable = 1'b0;
        tick();
        wait_idle("t3_idle");
        check_val("t3_reads", rd_addr.size(), 1);
        check_val("t3_rd_cyc", rd_cyc[0], c0 + 11);
        check_val("t3_rd_addr", rd_addr[0], 0);

        // Paced scrubbing, interval 3
        clear_log();
        interval = 16'd3; c0 = cyc; enable = 1'b1;
        wait_reads(3, "t4_reads");
        enable = 1'b0;
        wait_idle("t4_idle");
        interval = 16'd0;
        check_val("t4_first_cyc", rd_cyc[0], c0 + 4);
        check_val("t4_gap0", rd_cyc[1] - rd_cyc[0], 7);
        check_val("t4_gap1", rd_cyc[2] - rd_cyc[1], 7);
        check_val("t4_addr0", rd_addr[0], 1);
        check_val("t4_addr2", rd_addr[2], 3);

        // enable drops while the write-back waits on a busy memory
        preset(4'd4, 12'hF76);
        clear_log();
        enable = 1'b1;
        wait_reads(1, "t5_read");
        memory_busy = 1'b1; enable = 1'b0;
        repeat (6) tick();
        check_val("t5_no_wr_busy", wr_addr.size(), 0);
        check_val("t5_busy_mid", busy, 1);
        cw = cyc; memory_busy = 1'b0;
        tick();
        wait_idle("t5_idle");
        check_val("t5_writes", wr_addr.size(), 1);
        check_val("t5_waddr", wr_addr[0], 4);
        check_val("t5_wblk", wr_blk[0], 12'hF77);
        check_val("t5_wcyc", wr_cyc[0], cw);
        check_val("t5_cnt", corrected_count, 2);
        check_val("t5_reads", rd_addr.size(), 1);
        clear_log();
        enable = 1'b1;
        wait_reads(1, "t5_resume_read");
        enable = 1'b0;
        wait_idle("t5_resume_idle");
        check_val("t5_resume_addr", rd_addr[0], 5);

        // Reset during CHECK
        clear_log();
        enable = 1'b1;
        wait_reads(1, "t6_read");
        resetn = 1'b0;
        #1;
        check_val("t6_busy", busy, 0);
        check_val("t6_rd", read_enable, 0);
        check_val("t6_wr", write_enable, 0);
        check_val("t6_addr", read_address, 0);
        check_val("t6_cnt", corrected_count, 0);
        check_val("t6_pulse", corrected_pulse, 0);
        tick();
        clear_log();
        resetn = 1'b1;
        wait_reads(1, "t6_restart_read");
        enable = 1'b0;
        wait_idle("t6_idle");
        check_val("t6_restart_addr", rd_addr[0], 0);
        check_val("t6_writes", wr_addr.size(), 0);

        // Saturating counter on the narrow instance
        nz = 0;
        foreach (wr2_blk[i]) if (wr2_blk[i] != 12'h000) nz++;
        check_val("sat_writes", wr2_blk.size(), 16);
        check_val("sat_blocks", nz, 0);
        check_val("sat_cnt", count2, 3'h7);
        check_val("protocol", viol.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_scrubber.md
Name: hamming_scrubber

Overview:
- Background ECC scrubber for a Hamming-protected single-port memory. It walks every address and reads each stored block. It checks the block through the existing Hamming decode/encode datapath and writes back a re-encoded block when a single-bit error is found.
- Sits beside the functional memory port. Functional traffic always has priority, and the scrubber only issues an access in a cycle where the memory is idle.

Parameters:
- DATA_WIDTH, 8, payload bits per memory word.
- DEPTH, 16, number of memory words. Must be 2 or more.
- ADDRESS_WIDTH, $clog2(DEPTH), derived locally.
- BLOCK_WIDTH, DATA_WIDTH + Hamming parity width, derived locally. It is 12 for DATA_WIDTH=8.
- INTERVAL_WIDTH, 16, width of the inter-access pacing counter.
- COUNT_WIDTH, 16, width of the correction counter.

Ports:
- clock, input, 1, rising-edge clock.
- resetn, input, 1, asynchronous active-low reset.
- enable, input, 1, level; scrubbing runs while high.
- interval, input, INTERVAL_WIDTH, idle cycles between consecutive block scrubs.
- memory_busy, input, 1, functional port is using the memory this cycle.
- read_enable, output, 1, scrub read request.
- read_address, output, ADDRESS_WIDTH, scrub read address.
- read_block, input, BLOCK_WIDTH, read data, valid exactly 1 cycle after read_enable.
- write_enable, output, 1, scrub write-back request.
- write_address, output, ADDRESS_WIDTH, write-back address.
- write_block, output, BLOCK_WIDTH, corrected and re-encoded block.
- busy, output, 1, high in any state other than IDLE.
- corrected_pulse, output, 1, one-cycle pulse when a write-back is issued.
- sweep_done, output, 1, one-cycle pulse when the address wraps from DEPTH-1 to 0.
- corrected_count, output, COUNT_WIDTH, saturating count of write-backs.

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE; address and interval counter are 0.
  - All outputs are 0, including corrected_count.
  - Reset mid-read or mid-write abandons the operation and drives no strobe.
- IDLE: when enable=1, load the interval counter with interval and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; at 0 go to READ.
  - interval=0 gives back-to-back scrubs with no wait cycles.
- READ:
  - Assert read_enable with read_address=address combinationally, only in a cycle where memory_busy=0.
  - While memory_busy=1, hold in READ with no strobe.
  - After the strobe cycle, go to CHECK.
- CHECK:
  - Capture read_block (1-cycle read latency) into a register.
  - Go to EVALUATE on the next cycle.
- EVALUATE: the registered block feeds hamming_decoder (syndrome, corrected data), and the corrected data feeds hamming_encoder.
  - Syndrome 0: go to ADVANCE.
  - Syndrome nonzero: go to WRITE.
  - A syndrome pointing beyond BLOCK_WIDTH (padding) is treated as uncorrectable: no write, go to ADVANCE.
- WRITE:
  - Assert write_enable only when memory_busy=0, with write_address=address and write_block=the encoder block output.
  - In the same cycle, pulse corrected_pulse and increment corrected_count. The counter saturates at all-ones.
  - Then go to ADVANCE.
- ADVANCE:
  - Address increments, wrapping from DEPTH-1 to 0.
  - On wrap, pulse sweep_done for 1 cycle.
  - If enable=1, go to WAIT (reloading interval); otherwise go to IDLE.
- Latency, clean block with interval=0 and memory idle: READ, CHECK, EVALUATE, ADVANCE, giving 4 cycles per block. A corrected block takes 5 cycles.
- enable deasserted mid-scrub: the current block completes, including any pending write-back, then the block goes to IDLE. The address is retained, so the sweep resumes where it stopped.
- interval sampled only on the reload in IDLE or ADVANCE; changes mid-WAIT take effect on the next reload.
- read_enable and write_enable are never asserted together, and never asserted while memory_busy=1.

Decomposition:
- Package hamming_scrubber_pkg holds:
  - state enum (IDLE, WAIT, READ, CHECK, EVALUATE, WRITE, ADVANCE);
  - a parity-width helper reusing the existing Hamming width macros.
- Sub-modules: instantiate the existing hamming_decoder and hamming_encoder. No new sub-module is needed.

Test Plan (all with DATA_WIDTH=8, DEPTH=16):
1. Clean memory, interval=0, enable=1: 16 reads at addresses 0..15, each 4 cycles apart. sweep_done pulses once after address 15. No write_enable. corrected_count=0.
2. Address 5 holds a valid block for 0xA5 with block bit 6 flipped: write_enable at address 5 with write_block equal to the encoding of 0xA5. corrected_pulse is high for 1 cycle. corrected_count=1.
3. memory_busy held high for 10 cycles during READ: no read_enable for those 10 cycles. The read is issued in the first cycle memory_busy=0, with the address unchanged.
4. interval=3: exactly 3 WAIT cycles separate successive read_enable pulses, in addition to the 4-cycle pipeline.
5. enable dropped during a WRITE wait: the write completes, the block goes to IDLE, and busy=0. Re-enabling resumes at the next address.
6. resetn asserted during CHECK: all outputs go to 0 immediately. After release, the sweep restarts at address 0. corrected_count preset near saturation with injected errors holds at 0xFFFF.
